// File: rtl/rob_wb_arbiter_if.sv
// Writeback bus between the N_REQ execution units and the ROB write port.
// The arbiter uses the slave modport. Requesters and the ROB side use the master modport.
interface rob_wb_arbiter_if #(parameter int N_REQ = 3);
  logic [N_REQ-1:0]        s_valid;
  logic [N_REQ-1:0]        s_ready;
  logic [N_REQ-1:0][3:0]   s_rob;
  logic [N_REQ-1:0][7:0]   s_fid;
  logic [N_REQ-1:0][31:0]  s_value;
  logic [N_REQ-1:0]        s_lsmiss;
  logic [N_REQ-1:0][3:0]   s_cmtdelay;
  logic [N_REQ-1:0]        s_bco_valid;
  logic [N_REQ-1:0]        s_bco_taken;
  logic [N_REQ-1:0][1:0]   s_bco_pattern;
  logic [N_REQ-1:0][31:0]  s_bco_target;

  logic        en_writeback;
  logic [3:0]  addrd;
  logic [7:0]  dind_fid;
  logic [31:0] dind_value;
  logic        dind_lsmiss;
  logic [3:0]  dind_cmtdelay;
  logic        dind_bco_valid;
  logic [1:0]  dind_bco_pattern;
  logic        dind_bco_taken;
  logic [31:0] dind_bco_target;

  modport slave (
    input  s_valid, s_rob, s_fid, s_value, s_lsmiss, s_cmtdelay,
           s_bco_valid, s_bco_taken, s_bco_pattern, s_bco_target,
    output s_ready, en_writeback, addrd, dind_fid, dind_value, dind_lsmiss,
           dind_cmtdelay, dind_bco_valid, dind_bco_pattern, dind_bco_taken,
           dind_bco_target
  );

  modport master (
    output s_valid, s_rob, s_fid, s_value, s_lsmiss, s_cmtdelay,
           s_bco_valid, s_bco_taken, s_bco_pattern, s_bco_target,
    input  s_ready, en_writeback, addrd, dind_fid, dind_value, dind_lsmiss,
           dind_cmtdelay, dind_bco_valid, dind_bco_pattern, dind_bco_taken,
           dind_bco_target
  );
endinterface

// File: rtl/rob_wb_arbiter.sv
// ROB writeback arbiter. Each requester has a one-entry buffer, and one buffer is granted per cycle into a registered output stage.
// Define ROB_WB_ARB_ROUND_ROBIN_EN to get round-robin arbitration. Without it, the arbiter uses fixed priority (lowest index wins).
module rob_wb_lane #(parameter int W = 1) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         s_valid,
  input  logic         s_ready,
  input  logic         grant,
  input  logic [W-1:0] s_pay,
  output logic         buf_valid,
  output logic [W-1:0] buf_pay
);
  logic         vld_q, vld_d;
  logic [W-1:0] pay_q, pay_d;
  logic         cap;

  always_comb begin
    cap   = s_valid & s_ready;
    vld_d = vld_q;
    pay_d = pay_q;
    // A capture in the grant cycle is a refill, so the entry stays valid.
    if (flush)      vld_d = 1'b0;
    else if (cap)   vld_d = 1'b1;
    else if (grant) vld_d = 1'b0;
    if (cap) pay_d = s_pay;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  always_ff @(posedge clk) pay_q <= pay_d;

  assign buf_valid = vld_q;
  assign buf_pay   = pay_q;
endmodule

module rob_wb_arbiter #(parameter int N_REQ = 3) (
  input  logic             clk,
  input  logic             reset,
  input  logic             snoop_hit,
  input  logic             bco_valid,
  rob_wb_arbiter_if.slave  bus
);
  typedef struct packed {
    logic [3:0]  rob;
    logic [7:0]  fid;
    logic [31:0] value;
    logic        lsmiss;
    logic [3:0]  cmtdelay;
    logic        bco_valid;
    logic        bco_taken;
    logic [1:0]  bco_pattern;
    logic [31:0] bco_target;
  } wb_pay_t;

  localparam int W     = $bits(wb_pay_t);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                    flush;
  wb_pay_t [N_REQ-1:0]     in_pay;
  wb_pay_t [N_REQ-1:0]     buf_pay;
  logic    [N_REQ-1:0]     buf_valid;
  logic    [N_REQ-1:0]     gnt;
  logic                    gnt_any;
  logic    [PTR_W-1:0]     gnt_idx;
  logic                    en_q, en_d;
  wb_pay_t                 out_q, out_d;

  assign flush = bco_valid | snoop_hit;

  always_comb begin
    in_pay = '0;
    for (int i = 0; i < N_REQ; i++) begin
      in_pay[i].rob         = bus.s_rob[i];
      in_pay[i].fid         = bus.s_fid[i];
      in_pay[i].value       = bus.s_value[i];
      in_pay[i].lsmiss      = bus.s_lsmiss[i];
      in_pay[i].cmtdelay    = bus.s_cmtdelay[i];
      in_pay[i].bco_valid   = bus.s_bco_valid[i];
      in_pay[i].bco_taken   = bus.s_bco_taken[i];
      in_pay[i].bco_pattern = bus.s_bco_pattern[i];
      in_pay[i].bco_target  = bus.s_bco_target[i];
    end
  end

  // Grant is derived from the buffers only, so s_valid has no comb path to s_ready.
  assign bus.s_ready = (~buf_valid | gnt) & {N_REQ{~(flush | reset)}};

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      rob_wb_lane #(.W(W)) u_lane (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .s_valid   (bus.s_valid[gi]),
        .s_ready   (bus.s_ready[gi]),
        .grant     (gnt[gi]),
        .s_pay     (in_pay[gi]),
        .buf_valid (buf_valid[gi]),
        .buf_pay   (buf_pay[gi])
      );
    end
  endgenerate

`ifdef ROB_WB_ARB_ROUND_ROBIN_EN
  // ptr_q is the first index searched, one past the last winner.
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!flush && !reset) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!gnt_any && buf_valid[(int'(ptr_q) + k) % N_REQ]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
        end
      end
    end
    ptr_d = ptr_q;
    if (gnt_any)
      ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!flush && !reset) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!gnt_any && buf_valid[k]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(k);
        end
      end
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    en_d  = gnt_any;
    out_d = gnt_any ? buf_pay[gnt_idx] : out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= en_d;
  end

  always_ff @(posedge clk) out_q <= out_d;

  assign bus.en_writeback     = en_q;
  assign bus.addrd            = out_q.rob;
  assign bus.dind_fid         = out_q.fid;
  assign bus.dind_value       = out_q.value;
  assign bus.dind_lsmiss      = out_q.lsmiss;
  assign bus.dind_cmtdelay    = out_q.cmtdelay;
  assign bus.dind_bco_valid   = out_q.bco_valid;
  assign bus.dind_bco_pattern = out_q.bco_pattern;
  assign bus.dind_bco_taken   = out_q.bco_taken;
  assign bus.dind_bco_target  = out_q.bco_target;
endmodule
